// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_e;

    localparam int         OVERSAMPLE   = 16;
    localparam logic [3:0] START_SAMPLE = 4'd7;
    localparam logic [3:0] BIT_SAMPLE   = 4'd15;

    // Clock cycles per oversample tick; never below one so the divider stays legal.
    function automatic int calc_div(input int clk_hz, input int baud, input int oversample);
        int d;
        d = clk_hz / (baud * oversample);
        return (d < 1) ? 1 : d;
    endfunction

endpackage

// File: rtl/uart_rx_ctrl_if.sv
// Received-byte handshake between the UART receiver and its consumer.
interface uart_rx_ctrl_if;

    logic       rd_valid;
    logic       rd_ready;
    logic [7:0] rd_data;

    modport master (output rd_valid, output rd_data, input rd_ready);
    modport slave  (input rd_valid, input rd_data, output rd_ready);

endinterface

// File: rtl/uart_rx_ctrl_byte_fifo.sv
// Small byte queue; head entry is always visible, push and pop act in the same cycle.
module byte_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  logic [7:0] push_data,
    input  logic       pop,
    output logic       empty,
    output logic [7:0] head,
    output logic       drop
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    logic [7:0]    mem_q [DEPTH];
    logic [7:0]    mem_d [DEPTH];
    logic [AW-1:0] wr_q, wr_d;
    logic [AW-1:0] rd_q, rd_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push;
    logic          do_pop;

    always_comb begin
        do_pop  = pop && (count_q != '0);
        // A full queue still accepts a byte when the head leaves in the same cycle.
        do_push = push && ((count_q != CW'(DEPTH)) || do_pop);
        drop    = push && !do_push;
        mem_d   = mem_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        count_d = count_q;
        if (do_push) begin
            mem_d[wr_q] = push_data;
            wr_d        = wr_q + AW'(1);
        end
        if (do_pop) begin
            rd_d = rd_q + AW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            mem_q   <= mem_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
        end
    end

    assign empty = (count_q == '0);
    assign head  = mem_q[rd_q];

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receiver: pin synchroniser, 16x tick divider, start/data/stop sequencer and byte queue.
module uart_rx_ctrl #(
    parameter int CLK_HZ     = 100000000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx_in,
    uart_rx_ctrl_if.master    rd,
    output logic              frame_err,
    output logic              overflow,
    input  logic              err_clr,
    output logic              busy
);

    import uart_pkg::*;

    localparam int DIV   = calc_div(CLK_HZ, BAUD, OVERSAMPLE);
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;

    logic             sync1_q, sync2_q, prev_q;
    logic             rxs;
    logic [DIV_W-1:0] div_q, div_d;
    logic             tick;
    logic             div_clr;
    state_e           state_q, state_d;
    logic [3:0]       tc_q, tc_d;
    logic [2:0]       bc_q, bc_d;
    logic [7:0]       shift_q, shift_d;
    logic             push;
    logic             ferr_set;
    logic             frame_err_q, frame_err_d;
    logic             overflow_q, overflow_d;
    logic             fifo_empty;
    logic             fifo_drop;
    logic             pop;

    assign rxs  = sync2_q;
    assign tick = (div_q == DIV_W'(DIV - 1));

    always_comb begin
        state_d  = state_q;
        tc_d     = tc_q;
        bc_d     = bc_q;
        shift_d  = shift_q;
        push     = 1'b0;
        ferr_set = 1'b0;
        div_clr  = 1'b0;
        case (state_q)
            IDLE: begin
                // Restarting the divider here puts every sample at a fixed offset from the edge.
                if (prev_q && !rxs) begin
                    state_d = START;
                    tc_d    = '0;
                    div_clr = 1'b1;
                end
            end
            START: begin
                if (tick) begin
                    if (tc_q == START_SAMPLE) begin
                        tc_d = '0;
                        bc_d = '0;
                        state_d = rxs ? IDLE : DATA;
                    end else begin
                        tc_d = tc_q + 4'd1;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    if (tc_q == BIT_SAMPLE) begin
                        shift_d = {rxs, shift_q[7:1]};
                        tc_d    = '0;
                        if (bc_q == 3'd7) state_d = STOP;
                        else              bc_d    = bc_q + 3'd1;
                    end else begin
                        tc_d = tc_q + 4'd1;
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    if (tc_q == BIT_SAMPLE) begin
                        push     = rxs;
                        ferr_set = !rxs;
                        state_d  = IDLE;
                    end else begin
                        tc_d = tc_q + 4'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        div_d       = (div_clr || tick) ? '0 : div_q + DIV_W'(1);
        // A new error in the same cycle as a clear keeps the flag set.
        frame_err_d = ferr_set  ? 1'b1 : (err_clr ? 1'b0 : frame_err_q);
        overflow_d  = fifo_drop ? 1'b1 : (err_clr ? 1'b0 : overflow_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            prev_q      <= 1'b1;
            div_q       <= '0;
            state_q     <= IDLE;
            tc_q        <= '0;
            bc_q        <= '0;
            frame_err_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            sync1_q     <= rx_in;
            sync2_q     <= sync1_q;
            prev_q      <= sync2_q;
            div_q       <= div_d;
            state_q     <= state_d;
            tc_q        <= tc_d;
            bc_q        <= bc_d;
            frame_err_q <= frame_err_d;
            overflow_q  <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        shift_q <= shift_d;
    end

    assign pop = !fifo_empty && rd.rd_ready;

    byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (shift_q),
        .pop       (pop),
        .empty     (fifo_empty),
        .head      (rd.rd_data),
        .drop      (fifo_drop)
    );

    assign rd.rd_valid = !fifo_empty;
    assign frame_err   = frame_err_q;
    assign overflow    = overflow_q;
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl at 64 clocks per bit (DIV = 4).
module tb_uart_rx_ctrl;

    localparam int BAUD   = 9600;
    localparam int CLK_HZ = 64 * BAUD;
    localparam int BIT    = 64;

    logic clk;
    logic rst_n;
    logic rx_in;
    logic err_clr;
    logic frame_err;
    logic overflow;
    logic busy;

    int checks;
    int errors;
    logic [7:0] got[$];

    uart_rx_ctrl_if rd_if ();

    uart_rx_ctrl #(
        .CLK_HZ     (CLK_HZ),
        .BAUD       (BAUD),
        .OVERSAMPLE (16),
        .FIFO_DEPTH (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx_in     (rx_in),
        .rd        (rd_if),
        .frame_err (frame_err),
        .overflow  (overflow),
        .err_clr   (err_clr),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Log every accepted byte; sampled just after the falling edge.
    always @(negedge clk) begin
        #1;
        if (rst_n && rd_if.rd_valid && rd_if.rd_ready) got.push_back(rd_if.rd_data);
    end

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        @(negedge clk);
        rx_in = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_in = b[i];
            repeat (BIT) @(negedge clk);
        end
        rx_in = stop_bit;
        repeat (BIT) @(negedge clk);
        rx_in = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; rx_in = 1'b1; err_clr = 1'b0; rd_if.rd_ready = 1'b0;
        repeat (4) @(negedge clk);
        checks++; if (rd_if.rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid got %b exp 0", rd_if.rd_valid); end
        checks++; if (rd_if.rd_data !== 8'h00) begin errors++; $display("FAIL reset_rd_data got %h exp 00", rd_if.rd_data); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err got %b exp 0", frame_err); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b exp 0", overflow); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL post_reset_busy got %b exp 0", busy); end
    endtask

    task automatic test_single_byte();
        got.delete();
        rd_if.rd_ready = 1'b1;
        fork
            send_byte(8'h41, 1'b1);
            begin
                repeat (100) @(negedge clk);
                checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_mid got %b exp 1", busy); end
            end
        join
        repeat (10) @(negedge clk);
        checks++; if (got.size() != 1) begin errors++; $display("FAIL single_count got %0d exp 1", got.size()); end
        checks++; if (got.size() < 1 || got[0] !== 8'h41) begin errors++; $display("FAIL single_data got %h exp 41", (got.size() > 0) ? got[0] : 8'hxx); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL single_frame_err got %b exp 0", frame_err); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_end got %b exp 0", busy); end
    endtask

    task automatic test_glitch();
        got.delete();
        @(negedge clk);
        rx_in = 1'b0;
        repeat (15) @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL glitch_busy_start got %b exp 1", busy); end
        repeat (5) @(negedge clk);
        rx_in = 1'b1;
        repeat (100) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL glitch_busy_end got %b exp 0", busy); end
        checks++; if (got.size() != 0 || rd_if.rd_valid !== 1'b0) begin errors++; $display("FAIL glitch_push got %0d bytes valid %b exp 0 bytes valid 0", got.size(), rd_if.rd_valid); end
        checks++; if (frame_err !== 1'b0 || overflow !== 1'b0) begin errors++; $display("FAIL glitch_flags got %b%b exp 00", frame_err, overflow); end
    endtask

    task automatic test_frame_error();
        got.delete();
        send_byte(8'h55, 1'b0);
        repeat (16) @(negedge clk);
        checks++; if (got.size() != 0) begin errors++; $display("FAIL ferr_no_push got %0d bytes exp 0", got.size()); end
        checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL ferr_set got %b exp 1", frame_err); end
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL ferr_clear got %b exp 0", frame_err); end
        send_byte(8'hA5, 1'b1);
        repeat (10) @(negedge clk);
        checks++; if (got.size() != 1 || got[0] !== 8'hA5) begin errors++; $display("FAIL ferr_recover got %0d bytes first %h exp 1 byte a5", got.size(), (got.size() > 0) ? got[0] : 8'hxx); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL ferr_recover_flag got %b exp 0", frame_err); end
    endtask

    task automatic test_overflow();
        logic [7:0] exp_q[4];
        exp_q = '{8'h01, 8'h02, 8'h03, 8'h04};
        got.delete();
        rd_if.rd_ready = 1'b0;
        for (int i = 1; i <= 5; i++) send_byte(8'(i), 1'b1);
        repeat (10) @(negedge clk);
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set got %b exp 1", overflow); end
        checks++; if (rd_if.rd_valid !== 1'b1 || rd_if.rd_data !== 8'h01) begin errors++; $display("FAIL ovf_head got valid %b data %h exp valid 1 data 01", rd_if.rd_valid, rd_if.rd_data); end
        rd_if.rd_ready = 1'b1;
        repeat (10) @(negedge clk);
        checks++; if (got.size() != 4) begin errors++; $display("FAIL ovf_count got %0d exp 4", got.size()); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (got.size() <= i || got[i] !== exp_q[i]) begin errors++; $display("FAIL ovf_order[%0d] got %h exp %h", i, (got.size() > i) ? got[i] : 8'hxx, exp_q[i]); end
        end
        checks++; if (rd_if.rd_valid !== 1'b0) begin errors++; $display("FAIL ovf_drained got %b exp 0", rd_if.rd_valid); end
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear got %b exp 0", overflow); end
    endtask

    task automatic test_reset_mid_frame();
        got.delete();
        rd_if.rd_ready = 1'b1;
        fork
            send_byte(8'hFF, 1'b1);
            begin
                repeat (300) @(negedge clk);
                rst_n = 1'b0;
                @(negedge clk);
                checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got %b exp 0", busy); end
                repeat (2) @(negedge clk);
                rst_n = 1'b1;
                @(negedge clk);
                checks++; if (busy !== 1'b0 || rd_if.rd_valid !== 1'b0) begin errors++; $display("FAIL rst_release got busy %b valid %b exp 0 0", busy, rd_if.rd_valid); end
            end
        join
        send_byte(8'h3C, 1'b1);
        repeat (20) @(negedge clk);
        checks++; if (got.size() != 1 || got[0] !== 8'h3C) begin errors++; $display("FAIL rst_mid_data got %0d bytes first %h exp 1 byte 3c", got.size(), (got.size() > 0) ? got[0] : 8'hxx); end
    endtask

    task automatic test_back_to_back_full();
        logic [7:0] exp_q[5];
        exp_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h77};
        got.delete();
        rd_if.rd_ready = 1'b0;
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        send_byte(8'h33, 1'b1);
        send_byte(8'h44, 1'b1);
        // The stop-bit push of the fifth byte lands 611 clocks after its start edge is driven.
        fork
            send_byte(8'h77, 1'b1);
            begin
                @(negedge clk);
                repeat (610) @(negedge clk);
                rd_if.rd_ready = 1'b1;
                @(negedge clk);
                checks++; if (rd_if.rd_data !== 8'h22) begin errors++; $display("FAIL full_head_after got %h exp 22", rd_if.rd_data); end
            end
        join
        repeat (40) @(negedge clk);
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL full_overflow got %b exp 0", overflow); end
        checks++; if (got.size() != 5) begin errors++; $display("FAIL full_count got %0d exp 5", got.size()); end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (got.size() <= i || got[i] !== exp_q[i]) begin errors++; $display("FAIL full_order[%0d] got %h exp %h", i, (got.size() > i) ? got[i] : 8'hxx, exp_q[i]); end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_single_byte();
        test_glitch();
        test_frame_error();
        test_overflow();
        test_reset_mid_frame();
        test_back_to_back_full();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
